memory_access: RTL and testbench
================================

// Module: memory_access
// PURPOSE
// - Dual-lane MEM stage of the dual-issue MIPS pipeline; sits between the EX/MEM register and writeback.
// - Accepts an issued pair and serialises at most one data-bus access per lane, lane 0 first, over a dbus req/resp handshake.
// - Aligns and sign-extends load data, generates store strobes and flags misaligned accesses.
// - Presents a registered memory_data_t[1:0] pair (rd filled) for writeback to consume.
// PARAMETERS
// - ADDR_W   32  data-bus address width
// - MAX_WAIT 255 timeout cycles per access before sticky err_timeout (0 = no timeout)
// PORTS
// - clk           in   1                  stage clock
// - resetn        in   1                  async active-low reset
// - in_valid      in   1                  dataE holds a valid pair
// - in_ready      out  1                  pair accepted this cycle
// - dataE         in   execute_data_t[2]  lanes; uses valid, ctl.memtoreg, ctl.memwrite, ctl.msize(0 B/1 H/2 W), ctl.memsext, ctl.sc, alu_out (addr), srcb (store data)
// - flush         in   1                  kill the held pair (exception/ERET from CP0)
// - dreq_valid    out  1                  data-bus request valid
// - dreq_addr     out  ADDR_W             word-aligned address {addr[31:2],2'b0}
// - dreq_strobe   out  4                  byte enables; 0 = read
// - dreq_data     out  32                 store data shifted to byte lane
// - dresp_addr_ok in   1                  request accepted
// - dresp_data_ok in   1                  response valid (one per accepted request)
// - dresp_data    in   32                 read data
// - dataM         out  memory_data_t[2]   registered result pair
// - out_valid     out  1                  dataM valid
// - out_ready     in   1                  downstream consumes dataM
// - err_timeout   out  1                  sticky, cleared only by reset
// BEHAVIOUR
// - Reset (async, resetn=0): state IDLE.
//   - in_ready=1, out_valid=0, dreq_valid=0, dataM='0, err_timeout=0, llbit=0.
// - in_ready = (state==IDLE) || (state==DONE && out_ready). Handshake in_valid&&in_ready latches the pair into the held copy.
// - FSM: IDLE -> REQ0 -> WAIT0 -> REQ1 -> WAIT1 -> DONE; DRAIN for flushed in-flight accesses.
//   - A lane with no access (invalid, or not load/store) skips its REQ/WAIT states.
//   - A pair with no accesses reaches DONE the cycle after acceptance (1-cycle latency).
//   - REQn: dreq_valid=1, address/strobe/data held stable until dresp_addr_ok; then WAITn.
//   - WAITn: on dresp_data_ok, capture aligned data into lane n rd; go to the next lane's state or DONE.
//   - A same-cycle addr_ok+data_ok is legal and completes the access.
//   - DONE: out_valid=1, dataM stable until out_ready. out_ready with no new in_valid -> IDLE.
// - Misalignment:
//   - H with addr[0]!=0, or W with addr[1:0]!=0: no request issued.
//   - Lane cp0_ctl.ctype=EXCEPTION, with code AdEL for loads, AdES for stores.
//   - Lane 1 access is suppressed (passes through unaccessed) if lane 0 excepts.
// - Load alignment:
//   - B: byte = data[8*a+7 -: 8]; H: half = data[16*a[1]+15 -: 16].
//   - Zero-extend, or sign-extend when ctl.memsext.
// - Store:
//   - B: strobe = 4'b0001<<a, data replicated x4.
//   - H: strobe = 4'b0011<<a, data replicated x2.
//   - W: strobe = 4'hF.
// - Flush:
//   - Flush in IDLE/REQn/DONE drops the pair: out_valid=0 next cycle, dreq_valid deasserts unless addr_ok fires in the same cycle.
//   - Flush in WAITn, or coincident with addr_ok: go to DRAIN, swallow the pending data_ok, then IDLE; in_ready=0 while in DRAIN.
// - Timeout: counter reset on each REQ/WAIT entry. Reaching MAX_WAIT sets err_timeout; the FSM keeps waiting.
// - Non-memory dataM fields are copies of dataE (pc, rdst, ctl, alu_out, hilo, cp0_ctl, valid).
// CONFIGURATION
// - LLSC_EN defined:
//   - LL sets llbit when its load completes. flush or ERET in a held lane clears llbit.
//   - SC with llbit=1: stores normally, clears llbit.
//   - SC with llbit=0: no request, lane ctl.sc cleared, memtoreg set, rd=0, so writeback writes 0.
// - LLSC_EN undefined:
//   - No llbit; SC behaves as SW and keeps ctl.sc, so writeback writes 1.
// TESTING
// - Pair {ADD, OR}, out_ready=1 -> out_valid one cycle after accept, dreq_valid never high, dataM.alu_out copied.
// - Lane0 LB addr 0x1003 memsext, dresp_data 0x80xxxxxx -> dreq_addr 0x1000, strobe 0, rd 0xFFFFFF80; LBU -> 0x00000080.
// - Lane0 SH addr 0x2002 data 0x1234, lane1 LW 0x3000 -> first req strobe 4'b1100 data 0x12341234, then lane1 read; lane1 rd = dresp_data.
// - Lane0 LW addr 0x4001 -> no request, lane0 ctype EXCEPTION AdEL, lane1 SW not issued, out_valid next cycle.
// - Flush while in WAIT0, data_ok 3 cycles later -> in_ready=0 until data_ok, out_valid stays 0, returns to IDLE.
// - LLSC_EN: LL 0x5000, then SC 0x5000 -> store issued, rd path 1; flush, then SC -> no request, dataM rd=0, ctl.sc=0.

Source files
------------

// File: rtl/memory_access.sv
//==============================================================================
// Module   : memory_access (with memory_access_pkg)
// Purpose  : Dual-lane MEM stage; serialises one data-bus access per lane,
//            aligns load data, builds store strobes, flags misaligned access.
//            Optional LL/SC link bit support when LLSC_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package memory_access_pkg;
    localparam logic [1:0] c_msize_b          = 2'd0;
    localparam logic [1:0] c_msize_h          = 2'd1;
    localparam logic [1:0] c_msize_w          = 2'd2;
    localparam logic [1:0] c_ctype_none       = 2'd0;
    localparam logic [1:0] c_ctype_exception  = 2'd1;
    localparam logic [1:0] c_ctype_eret       = 2'd2;
    localparam logic [4:0] c_exc_adel         = 5'h04;
    localparam logic [4:0] c_exc_ades         = 5'h05;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic [1:0] msize;
        logic       memsext;
        logic       ll;
        logic       sc;
    } ctl_t;

    typedef struct packed {
        logic [1:0] ctype;
        logic [4:0] code;
    } cp0_ctl_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rdst;
        ctl_t        ctl;
        logic [31:0] alu_out;
        logic [31:0] srcb;
        logic [63:0] hilo;
        cp0_ctl_t    cp0_ctl;
    } execute_data_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rdst;
        ctl_t        ctl;
        logic [31:0] alu_out;
        logic [63:0] hilo;
        cp0_ctl_t    cp0_ctl;
        logic [31:0] rd;
    } memory_data_t;
endpackage

module memory_access
    import memory_access_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  execute_data_t [1:0]     dataE,
    input  logic                    flush,
    output logic                    dreq_valid,
    output logic [ADDR_W-1:0]       dreq_addr,
    output logic [3:0]              dreq_strobe,
    output logic [31:0]             dreq_data,
    input  logic                    dresp_addr_ok,
    input  logic                    dresp_data_ok,
    input  logic [31:0]             dresp_data,
    output memory_data_t [1:0]      dataM,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err_timeout
);

    localparam int              CNT_W      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] c_max_wait = CNT_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_DONE  = 3'd5,
        S_DRAIN = 3'd6
    } state_t;

    state_t              r_state, w_next, w_first, w_after;
    memory_data_t [1:0]  r_out, w_pre;
    logic [1:0]          r_go, w_go;
    logic [1:0][31:0]    r_addr, r_wdata;
    logic [1:0][1:0]     r_msize;
    logic [1:0]          r_sext, r_load, r_store;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;
    logic                w_accept, w_done, w_lane, w_busy, w_entry;
    logic                w_mis0, w_mis1, w_blk1;
    logic [1:0]          w_off;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load;
`ifdef LLSC_EN
    logic                r_llbit, w_ll_l1, w_eret;
    logic [1:0]          r_ll, r_sc;
`endif

    function automatic logic is_mem(input execute_data_t d);
        return d.valid && (d.ctl.memtoreg || d.ctl.memwrite) &&
               (d.cp0_ctl.ctype != c_ctype_exception);
    endfunction

    function automatic logic is_mis(input execute_data_t d);
        return ((d.ctl.msize == c_msize_h) && d.alu_out[0]) ||
               (d.ctl.msize[1] && (d.alu_out[1:0] != 2'b00));
    endfunction

    function automatic memory_data_t pass_through(input execute_data_t d);
        memory_data_t m;
        m         = '0;
        m.valid   = d.valid;
        m.pc      = d.pc;
        m.rdst    = d.rdst;
        m.ctl     = d.ctl;
        m.alu_out = d.alu_out;
        m.hilo    = d.hilo;
        m.cp0_ctl = d.cp0_ctl;
        return m;
    endfunction

    assign in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept = in_valid && in_ready && !flush;

    // Decode of the incoming pair: which lanes touch the bus, which except.
    always_comb begin
        w_pre[0] = pass_through(dataE[0]);
        w_pre[1] = pass_through(dataE[1]);
        w_mis0   = is_mem(dataE[0]) && is_mis(dataE[0]);
        // An excepting lane 0 must not be followed by a lane 1 bus access.
        w_blk1   = w_mis0 || (dataE[0].valid && (dataE[0].cp0_ctl.ctype == c_ctype_exception));
        w_mis1   = !w_blk1 && is_mem(dataE[1]) && is_mis(dataE[1]);
        w_go[0]  = is_mem(dataE[0]) && !w_mis0;
        w_go[1]  = !w_blk1 && is_mem(dataE[1]) && !w_mis1;
        if (w_mis0) begin
            w_pre[0].cp0_ctl.ctype = c_ctype_exception;
            w_pre[0].cp0_ctl.code  = dataE[0].ctl.memwrite ? c_exc_ades : c_exc_adel;
        end
        if (w_mis1) begin
            w_pre[1].cp0_ctl.ctype = c_ctype_exception;
            w_pre[1].cp0_ctl.code  = dataE[1].ctl.memwrite ? c_exc_ades : c_exc_adel;
        end
`ifdef LLSC_EN
        // Lane 1 sees the link bit as lane 0 will leave it.
        w_ll_l1 = r_llbit;
        if (w_go[0] && dataE[0].ctl.memwrite && dataE[0].ctl.sc)
            w_ll_l1 = 1'b0;
        else if (w_go[0] && dataE[0].ctl.memtoreg && dataE[0].ctl.ll)
            w_ll_l1 = 1'b1;
        if (w_go[0] && dataE[0].ctl.memwrite && dataE[0].ctl.sc && !r_llbit) begin
            w_go[0]              = 1'b0;
            w_pre[0].ctl.sc       = 1'b0;
            w_pre[0].ctl.memtoreg = 1'b1;
        end
        if (w_go[1] && dataE[1].ctl.memwrite && dataE[1].ctl.sc && !w_ll_l1) begin
            w_go[1]              = 1'b0;
            w_pre[1].ctl.sc       = 1'b0;
            w_pre[1].ctl.memtoreg = 1'b1;
        end
        w_eret = (dataE[0].valid && (dataE[0].cp0_ctl.ctype == c_ctype_eret)) ||
                 (dataE[1].valid && (dataE[1].cp0_ctl.ctype == c_ctype_eret));
`endif
    end

    // Active-lane datapath
    assign w_lane = (r_state == S_REQ1) || (r_state == S_WAIT1);
    assign w_off  = r_addr[w_lane][1:0];
    assign w_byte = dresp_data[{w_off, 3'b000} +: 8];
    assign w_half = w_off[1] ? dresp_data[31:16] : dresp_data[15:0];

    always_comb begin
        w_load      = dresp_data;
        dreq_strobe = 4'h0;
        dreq_data   = r_wdata[w_lane];
        case (r_msize[w_lane])
            c_msize_b: begin
                w_load    = r_sext[w_lane] ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
                dreq_data = {4{r_wdata[w_lane][7:0]}};
                if (r_store[w_lane]) dreq_strobe = 4'b0001 << w_off;
            end
            c_msize_h: begin
                w_load    = r_sext[w_lane] ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
                dreq_data = {2{r_wdata[w_lane][15:0]}};
                if (r_store[w_lane]) dreq_strobe = 4'b0011 << w_off;
            end
            default: begin
                if (r_store[w_lane]) dreq_strobe = 4'hF;
            end
        endcase
    end

    assign dreq_addr = ADDR_W'({r_addr[w_lane][31:2], 2'b00});

    always_comb begin
        w_first    = w_go[0] ? S_REQ0 : (w_go[1] ? S_REQ1 : S_DONE);
        w_after    = (!w_lane && r_go[1]) ? S_REQ1 : S_DONE;
        w_next     = r_state;
        w_done     = 1'b0;
        dreq_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = w_first;
            end
            S_REQ0, S_REQ1: begin
                dreq_valid = 1'b1;
                if (flush) begin
                    w_next = (dresp_addr_ok && !dresp_data_ok) ? S_DRAIN : S_IDLE;
                end else if (dresp_addr_ok) begin
                    if (dresp_data_ok) begin
                        w_done = 1'b1;
                        w_next = w_after;
                    end else begin
                        w_next = (r_state == S_REQ0) ? S_WAIT0 : S_WAIT1;
                    end
                end
            end
            S_WAIT0, S_WAIT1: begin
                if (flush) begin
                    w_next = dresp_data_ok ? S_IDLE : S_DRAIN;
                end else if (dresp_data_ok) begin
                    w_done = 1'b1;
                    w_next = w_after;
                end
            end
            S_DONE: begin
                if (flush)          w_next = S_IDLE;
                else if (out_ready) w_next = w_accept ? w_first : S_IDLE;
            end
            S_DRAIN: begin
                if (dresp_data_ok) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_busy  = (r_state == S_REQ0) || (r_state == S_WAIT0) ||
                     (r_state == S_REQ1) || (r_state == S_WAIT1);
    assign w_entry = (w_next != r_state) &&
                     ((w_next == S_REQ0) || (w_next == S_WAIT0) ||
                      (w_next == S_REQ1) || (w_next == S_WAIT1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_go    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_msize <= '0;
            r_sext  <= '0;
            r_load  <= '0;
            r_store <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_out <= w_pre;
                r_go  <= w_go;
                for (int i = 0; i < 2; i++) begin
                    r_addr[i]  <= dataE[i].alu_out;
                    r_wdata[i] <= dataE[i].srcb;
                    r_msize[i] <= dataE[i].ctl.msize;
                    r_sext[i]  <= dataE[i].ctl.memsext;
                    r_load[i]  <= dataE[i].ctl.memtoreg;
                    r_store[i] <= dataE[i].ctl.memwrite;
                end
            end else if (w_done && r_load[w_lane]) begin
                r_out[w_lane].rd <= w_load;
            end
            if (w_entry)
                r_cnt <= '0;
            else if (w_busy && (r_cnt != c_max_wait))
                r_cnt <= r_cnt + 1'b1;
            if ((MAX_WAIT != 0) && w_busy && (r_cnt == c_max_wait))
                r_err <= 1'b1;
        end
    end

`ifdef LLSC_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_llbit <= 1'b0;
            r_ll    <= '0;
            r_sc    <= '0;
        end else begin
            if (w_accept) begin
                r_ll <= {dataE[1].ctl.ll, dataE[0].ctl.ll};
                r_sc <= {dataE[1].ctl.sc, dataE[0].ctl.sc};
            end
            if (flush || (w_accept && w_eret))
                r_llbit <= 1'b0;
            else if (w_done && r_load[w_lane] && r_ll[w_lane])
                r_llbit <= 1'b1;
            else if (w_done && r_store[w_lane] && r_sc[w_lane])
                r_llbit <= 1'b0;
        end
    end
`endif

    assign dataM       = r_out;
    assign out_valid   = (r_state == S_DONE);
    assign err_timeout = r_err;

endmodule

`default_nettype wire

// File: tb/tb_memory_access.sv
//==============================================================================
// Module   : tb_memory_access
// Purpose  : Directed self-checking bench for memory_access (both LLSC_EN builds).
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_memory_access;
    import memory_access_pkg::*;

    localparam int MAX_WAIT = 8;

    logic                clk = 1'b0;
    logic                resetn;
    logic                in_valid, in_ready, flush;
    execute_data_t [1:0] dataE;
    logic                dreq_valid;
    logic [31:0]         dreq_addr;
    logic [3:0]          dreq_strobe;
    logic [31:0]         dreq_data;
    logic                dresp_addr_ok, dresp_data_ok;
    logic [31:0]         dresp_data;
    memory_data_t [1:0]  dataM;
    logic                out_valid, out_ready, err_timeout;

    int n_vec = 0;
    int n_err = 0;
    int n_req = 0;
    int base;

    memory_access #(.ADDR_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .dataE(dataE), .flush(flush), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data), .dataM(dataM),
        .out_valid(out_valid), .out_ready(out_ready), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dreq_valid) n_req <= n_req + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic execute_data_t alu_op(input logic [31:0] pc, input logic [31:0] res);
        execute_data_t d;
        d              = '0;
        d.valid        = 1'b1;
        d.pc           = pc;
        d.rdst         = 5'd3;
        d.ctl.regwrite = 1'b1;
        d.alu_out      = res;
        return d;
    endfunction

    function automatic execute_data_t mem_op(input logic ld, input logic [1:0] sz, input logic sext,
                                             input logic [31:0] addr, input logic [31:0] wd);
        execute_data_t d;
        d              = alu_op(32'h400, addr);
        d.ctl.regwrite = ld;
        d.ctl.memtoreg = ld;
        d.ctl.memwrite = !ld;
        d.ctl.msize    = sz;
        d.ctl.memsext  = sext;
        d.srcb         = wd;
        return d;
    endfunction

    task automatic issue(input execute_data_t l0, input execute_data_t l1);
        dataE[0] = l0;
        dataE[1] = l1;
        in_valid = 1'b1;
        chk("in_ready_at_issue", in_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic serve(input string tag, input logic [31:0] eaddr, input logic [3:0] estrb,
                         input logic [31:0] edata, input logic [31:0] rdata, input int hold, input int gap);
        int t = 0;
        while (!dreq_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_req_valid"}, dreq_valid, 1'b1);
        if (dreq_valid) begin
            repeat (hold) @(negedge clk);
            chk({tag, "_addr"}, dreq_addr, eaddr);
            chk({tag, "_strobe"}, dreq_strobe, estrb);
            if (estrb != 4'h0) chk({tag, "_wdata"}, dreq_data, edata);
            dresp_addr_ok = 1'b1;
            if (gap == 0) begin
                dresp_data_ok = 1'b1;
                dresp_data    = rdata;
            end
            @(posedge clk); @(negedge clk);
            dresp_addr_ok = 1'b0;
            dresp_data_ok = 1'b0;
            if (gap > 0) begin
                repeat (gap - 1) @(negedge clk);
                dresp_data_ok = 1'b1;
                dresp_data    = rdata;
                @(posedge clk); @(negedge clk);
                dresp_data_ok = 1'b0;
            end
        end
    endtask

    task automatic await_out(input string tag);
        int t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_out_valid"}, out_valid, 1'b1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
    endtask

    execute_data_t e;

    initial begin
        resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; dataE = '0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_dreq_valid", dreq_valid, 1'b0);
        chk("rst_dataM_zero", |dataM, 1'b0);
        chk("rst_err_timeout", err_timeout, 1'b0);
        resetn = 1'b1;
        @(negedge clk);

        // ALU-only pair: one-cycle latency, no bus traffic
        base = n_req;
        issue(alu_op(32'h100, 32'h11), alu_op(32'h104, 32'h22));
        chk("alu_out_valid", out_valid, 1'b1);
        chk("alu_l0_alu_out", dataM[0].alu_out, 32'h11);
        chk("alu_l1_alu_out", dataM[1].alu_out, 32'h22);
        chk("alu_l1_pc", dataM[1].pc, 32'h104);
        consume();
        chk("alu_out_valid_after", out_valid, 1'b0);
        chk("alu_no_dreq", n_req - base, 0);

        // Byte/half loads with alignment and extension
        issue(mem_op(1'b1, c_msize_b, 1'b1, 32'h1003, 32'h0), alu_op(32'h108, 32'h0));
        serve("lb", 32'h1000, 4'h0, 32'h0, 32'h8012_3456, 0, 0);
        await_out("lb");
        chk("lb_rd", dataM[0].rd, 32'hFFFF_FF80);
        consume();
        issue(mem_op(1'b1, c_msize_b, 1'b0, 32'h1003, 32'h0), alu_op(32'h108, 32'h0));
        serve("lbu", 32'h1000, 4'h0, 32'h0, 32'h8012_3456, 0, 0);
        await_out("lbu");
        chk("lbu_rd", dataM[0].rd, 32'h0000_0080);
        consume();
        issue(mem_op(1'b1, c_msize_h, 1'b1, 32'h1002, 32'h0), mem_op(1'b1, c_msize_h, 1'b0, 32'h1000, 32'h0));
        serve("lh", 32'h1000, 4'h0, 32'h0, 32'h8001_ABCD, 0, 0);
        serve("lhu", 32'h1000, 4'h0, 32'h0, 32'h8001_ABCD, 0, 1);
        await_out("lh_lhu");
        chk("lh_rd", dataM[0].rd, 32'hFFFF_8001);
        chk("lhu_rd", dataM[1].rd, 32'h0000_ABCD);
        consume();

        // Store then load, store held while addr_ok is withheld
        issue(mem_op(1'b0, c_msize_h, 1'b0, 32'h2002, 32'h0000_1234),
              mem_op(1'b1, c_msize_w, 1'b0, 32'h3000, 32'h0));
        serve("sh", 32'h2000, 4'b1100, 32'h1234_1234, 32'h0, 3, 0);
        serve("lw", 32'h3000, 4'h0, 32'h0, 32'hCAFE_F00D, 0, 2);
        await_out("sh_lw");
        chk("sh_rd", dataM[0].rd, 32'h0);
        chk("lw_rd", dataM[1].rd, 32'hCAFE_F00D);
        consume();
        issue(alu_op(32'h10C, 32'h5), mem_op(1'b0, c_msize_b, 1'b0, 32'h2001, 32'h0000_00AB));
        serve("sb", 32'h2000, 4'b0010, 32'hABAB_ABAB, 32'h0, 0, 0);
        await_out("sb");
        consume();
        chk("no_timeout_yet", err_timeout, 1'b0);

        // Misaligned accesses raise AdEL/AdES without touching the bus
        base = n_req;
        issue(mem_op(1'b1, c_msize_w, 1'b0, 32'h4001, 32'h0), mem_op(1'b0, c_msize_w, 1'b0, 32'h4100, 32'h9));
        chk("adel_out_valid", out_valid, 1'b1);
        chk("adel_ctype", dataM[0].cp0_ctl.ctype, c_ctype_exception);
        chk("adel_code", dataM[0].cp0_ctl.code, c_exc_adel);
        chk("adel_l1_ctype", dataM[1].cp0_ctl.ctype, c_ctype_none);
        consume();
        issue(alu_op(32'h110, 32'h1), mem_op(1'b0, c_msize_h, 1'b0, 32'h4003, 32'h9));
        chk("ades_out_valid", out_valid, 1'b1);
        chk("ades_ctype", dataM[1].cp0_ctl.ctype, c_ctype_exception);
        chk("ades_code", dataM[1].cp0_ctl.code, c_exc_ades);
        consume();
        chk("mis_no_dreq", n_req - base, 0);

        // Flush while waiting for data: drain the outstanding response
        issue(mem_op(1'b1, c_msize_w, 1'b0, 32'h6000, 32'h0), alu_op(32'h114, 32'h0));
        chk("fl_req_valid", dreq_valid, 1'b1);
        dresp_addr_ok = 1'b1;
        @(posedge clk); @(negedge clk);
        dresp_addr_ok = 1'b0;
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        chk("drain_in_ready_1", in_ready, 1'b0);
        @(negedge clk);
        chk("drain_in_ready_2", in_ready, 1'b0);
        chk("drain_out_valid", out_valid, 1'b0);
        dresp_data_ok = 1'b1;
        @(posedge clk); @(negedge clk);
        dresp_data_ok = 1'b0;
        chk("drain_idle_in_ready", in_ready, 1'b1);
        chk("drain_idle_out_valid", out_valid, 1'b0);
        chk("drain_idle_dreq", dreq_valid, 1'b0);

        // Flush during REQ drops the request
        issue(mem_op(1'b1, c_msize_w, 1'b0, 32'h6100, 32'h0), alu_op(32'h118, 32'h0));
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        chk("flreq_dreq", dreq_valid, 1'b0);
        chk("flreq_in_ready", in_ready, 1'b1);

`ifdef LLSC_EN
        e = mem_op(1'b1, c_msize_w, 1'b0, 32'h5000, 32'h0);
        e.ctl.ll = 1'b1;
        issue(e, alu_op(32'h120, 32'h0));
        serve("ll", 32'h5000, 4'h0, 32'h0, 32'h0BAD_F00D, 0, 0);
        await_out("ll");
        consume();
        e = mem_op(1'b0, c_msize_w, 1'b0, 32'h5000, 32'h77);
        e.ctl.sc = 1'b1;
        issue(e, alu_op(32'h124, 32'h0));
        serve("sc_ok", 32'h5000, 4'hF, 32'h77, 32'h0, 0, 0);
        await_out("sc_ok");
        chk("sc_ok_sc", dataM[0].ctl.sc, 1'b1);
        consume();
        e = mem_op(1'b1, c_msize_w, 1'b0, 32'h5000, 32'h0);
        e.ctl.ll = 1'b1;
        issue(e, alu_op(32'h128, 32'h0));
        serve("ll2", 32'h5000, 4'h0, 32'h0, 32'h1, 0, 0);
        await_out("ll2");
        consume();
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        base = n_req;
        e = mem_op(1'b0, c_msize_w, 1'b0, 32'h5000, 32'h77);
        e.ctl.sc = 1'b1;
        issue(e, alu_op(32'h12C, 32'h0));
        chk("sc_fail_out_valid", out_valid, 1'b1);
        chk("sc_fail_rd", dataM[0].rd, 32'h0);
        chk("sc_fail_sc", dataM[0].ctl.sc, 1'b0);
        chk("sc_fail_memtoreg", dataM[0].ctl.memtoreg, 1'b1);
        chk("sc_fail_no_dreq", n_req - base, 0);
        consume();
`else
        e = mem_op(1'b0, c_msize_w, 1'b0, 32'h5000, 32'h77);
        e.ctl.sc = 1'b1;
        issue(e, alu_op(32'h120, 32'h0));
        serve("sc_sw", 32'h5000, 4'hF, 32'h77, 32'h0, 0, 0);
        await_out("sc_sw");
        chk("sc_sw_sc", dataM[0].ctl.sc, 1'b1);
        consume();
`endif

        // Timeout: sticky flag, FSM keeps waiting
        issue(mem_op(1'b1, c_msize_w, 1'b0, 32'h7000, 32'h0), alu_op(32'h130, 32'h0));
        serve("slow", 32'h7000, 4'h0, 32'h0, 32'h1357_9BDF, 12, 0);
        chk("timeout_set", err_timeout, 1'b1);
        await_out("slow");
        chk("slow_rd", dataM[0].rd, 32'h1357_9BDF);
        consume();
        chk("timeout_sticky", err_timeout, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
